// File: rtl/vid_frame_read_scheduler_if.sv
// Read-command channel between the frame read scheduler and the memory reader.
// The scheduler is the master: it drives the burst command and receives the handshakes.
interface vid_frame_read_scheduler_if #(
  parameter int ADDR_W = 28
);
  logic              o_rd_req;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [7:0]        o_rd_len;
  logic              i_rd_ack;
  logic              i_rd_done;

  modport master (output o_rd_req, o_rd_addr, o_rd_len, input i_rd_ack, i_rd_done);
  modport slave  (input o_rd_req, o_rd_addr, o_rd_len, output i_rd_ack, i_rd_done);
endinterface

// File: rtl/vid_frame_read_scheduler.sv
// Per-frame burst read scheduler: restarts at each display VS edge, throttles bursts
// on line-FIFO fill level, keeps one burst outstanding, and flags underflow / late VS.
module vid_frame_read_scheduler #(
  parameter int H_ACTIVE        = 1280,
  parameter int V_ACTIVE        = 720,
  parameter int BURST_LEN       = 64,
  parameter int FIFO_DEPTH      = 2048,
  parameter int BYTES_PER_PIXEL = 4,
  parameter int ADDR_W          = 28,
  parameter int VS_POLARITY     = 1,
  parameter int FLUSH_CYCLES    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_vs,
  input  logic                 i_de,
  input  logic [ADDR_W-1:0]    i_frame_base,
  input  logic [11:0]          i_fifo_level,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_flush,
  vid_frame_read_scheduler_if.master rd_if,
  output logic                 o_busy,
  output logic                 o_underflow,
  output logic                 o_late_vs,
  input  logic                 i_err_clr
);

  localparam logic              VS_ACT     = 1'(VS_POLARITY);
  localparam logic [20:0]       TOTAL      = 21'(H_ACTIVE * V_ACTIVE);
  localparam logic [12:0]       DEPTH13    = 13'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BPP_A      = ADDR_W'(BYTES_PER_PIXEL);
  localparam int                CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_WAIT_SPACE, S_REQ, S_WAIT_DONE, S_FRAME_END
  } state_t;

  state_t            r_state, w_next;
  logic              r_vs_prev, r_edge, r_vs_pending;
  logic [ADDR_W-1:0] r_base, r_rd_ptr, r_rd_addr;
  logic [20:0]       r_remaining;
  logic [7:0]        r_rd_len;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_underflow, r_late_vs;
  logic              w_edge, w_restart, w_fits, w_late_evt, w_uf_evt;
  logic [7:0]        w_len;
  logic [ADDR_W-1:0] w_step;

  function automatic logic [7:0] f_burst_len(input logic [20:0] rem);
    if (rem < 21'(BURST_LEN)) f_burst_len = rem[7:0];
    else                      f_burst_len = 8'(BURST_LEN);
  endfunction

  assign w_edge     = (i_vs == VS_ACT) && (r_vs_prev != VS_ACT);
  assign w_len      = f_burst_len(r_remaining);
  assign w_fits     = ({1'b0, i_fifo_level} + {5'd0, w_len}) <= DEPTH13;
  assign w_step     = ADDR_W'(r_rd_len) * BPP_A;
  assign w_late_evt = r_edge && (r_state == S_WAIT_SPACE || r_state == S_REQ ||
                                 r_state == S_WAIT_DONE);
  assign w_uf_evt   = i_de && i_fifo_empty && (r_state != S_IDLE) && (r_state != S_FLUSH);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // A pending VS never abandons a command: REQ waits for its ack, WAIT_DONE for its done.
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    case (r_state)
      S_IDLE, S_FRAME_END: begin
        if (r_edge) begin
          w_next    = S_FLUSH;
          w_restart = 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_edge)                          w_restart = 1'b1;
        else if (r_flush_cnt == FLUSH_LAST)  w_next    = S_WAIT_SPACE;
      end
      S_WAIT_SPACE: begin
        if (r_edge) begin
          w_next    = S_FLUSH;
          w_restart = 1'b1;
        end else if (r_remaining == '0) begin
          w_next = S_FRAME_END;
        end else if (w_fits) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_if.i_rd_ack) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (rd_if.i_rd_done) begin
          if (r_vs_pending || r_edge) begin
            w_next    = S_FLUSH;
            w_restart = 1'b1;
          end else begin
            w_next = S_WAIT_SPACE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Base is captured on the raw edge so it is ready when the registered edge restarts the frame.
  always_ff @(posedge i_clk) begin
    if (w_edge) r_base <= i_frame_base;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_prev    <= VS_ACT;
      r_edge       <= 1'b0;
      r_vs_pending <= 1'b0;
      r_rd_ptr     <= '0;
      r_remaining  <= '0;
      r_flush_cnt  <= '0;
      r_rd_addr    <= '0;
      r_rd_len     <= '0;
      r_underflow  <= 1'b0;
      r_late_vs    <= 1'b0;
    end else begin
      r_vs_prev <= i_vs;
      r_edge    <= w_edge;
      if (w_restart) begin
        r_rd_ptr     <= r_base;
        r_remaining  <= TOTAL;
        r_flush_cnt  <= '0;
        r_vs_pending <= 1'b0;
      end else begin
        if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        if (r_state == S_REQ && rd_if.i_rd_ack) begin
          r_rd_ptr    <= r_rd_ptr + w_step;
          r_remaining <= r_remaining - 21'(r_rd_len);
        end
        if (r_edge && (r_state == S_REQ || r_state == S_WAIT_DONE)) r_vs_pending <= 1'b1;
      end
      if (r_state == S_WAIT_SPACE && w_next == S_REQ) begin
        r_rd_addr <= r_rd_ptr;
        r_rd_len  <= w_len;
      end
      if (w_late_evt)     r_late_vs <= 1'b1;
      else if (i_err_clr) r_late_vs <= 1'b0;
      if (w_uf_evt)       r_underflow <= 1'b1;
      else if (i_err_clr) r_underflow <= 1'b0;
    end
  end

  assign o_fifo_flush    = (r_state == S_FLUSH);
  assign o_busy          = (r_state != S_IDLE) && (r_state != S_FRAME_END);
  assign o_underflow     = r_underflow;
  assign o_late_vs       = r_late_vs;
  assign rd_if.o_rd_req  = (r_state == S_REQ);
  assign rd_if.o_rd_addr = r_rd_addr;
  assign rd_if.o_rd_len  = r_rd_len;

endmodule

// File: doc/vid_frame_read_scheduler.md
Name: vid_frame_read_scheduler

Overview:
- Sequences per-frame memory read bursts that prefetch display pixels into the line FIFO feeding the video timing generator.
- Restarts at every display VS leading edge from a latched frame base address, throttled by FIFO fill level.
- Issues one outstanding burst at a time on a simple req/ack/done command port.
- Flags display-side underflow.

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- BURST_LEN, 64, maximum pixels per read burst (1..255).
- FIFO_DEPTH, 2048, line FIFO capacity in pixels.
- BYTES_PER_PIXEL, 4, address stride per pixel.
- ADDR_W, 28, memory byte-address width.
- VS_POLARITY, 1, active level of i_vs (1 = active-high).
- FLUSH_CYCLES, 4, cycles o_fifo_flush is held per frame start.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  reset (already decided)
- i_vs  in  1  display vertical sync from the timing generator
- i_de  in  1  display data enable (FIFO pop qualifier)
- i_frame_base  in  ADDR_W  byte address of the frame to display, sampled at VS edge
- i_fifo_level  in  12  pixels currently stored in the line FIFO
- i_fifo_empty  in  1  line FIFO empty
- o_fifo_flush  out  1  synchronous FIFO clear
- o_rd_req  out  1  read command valid
- o_rd_addr  out  ADDR_W  burst start byte address
- o_rd_len  out  8  burst length in pixels
- i_rd_ack  in  1  command accepted (single cycle, only while o_rd_req=1)
- i_rd_done  in  1  last pixel of the accepted burst written to the FIFO (single cycle)
- o_busy  out  1  frame fetch in progress (any state except IDLE/FRAME_END)
- o_underflow  out  1  sticky: i_de=1 while i_fifo_empty=1
- o_late_vs  out  1  sticky: VS edge arrived before the previous frame finished fetching
- i_err_clr  in  1  clears o_underflow and o_late_vs

Behaviour:
- Reset (async, active-low):
  - state = IDLE.
  - All outputs 0; o_rd_addr = 0, o_rd_len = 0.
  - Internal pointer and remaining counter = 0.
  - Reset mid-burst abandons the transaction; memory side is reset by the same net.
- VS edge detection:
  - Register i_vs; edge = (i_vs==VS_POLARITY) && (prev != VS_POLARITY).
  - Edge is acted on one cycle after it is seen.
- Frame start, on edge:
  - rd_ptr <= i_frame_base.
  - remaining <= H_ACTIVE*V_ACTIVE (21-bit).
  - Enter FLUSH.
- FSM states:
  - IDLE: wait for edge.
  - FLUSH: o_fifo_flush=1 for exactly FLUSH_CYCLES cycles, then WAIT_SPACE.
  - WAIT_SPACE:
    - remaining==0: go to FRAME_END.
    - Otherwise len = min(BURST_LEN, remaining). If i_fifo_level <= FIFO_DEPTH-len, go to REQ next cycle with o_rd_addr = rd_ptr and o_rd_len = len registered.
  - REQ:
    - o_rd_req=1; addr and len held stable until i_rd_ack.
    - On ack: o_rd_req=0 the next cycle, rd_ptr += len*BYTES_PER_PIXEL, remaining -= len, go to WAIT_DONE.
  - WAIT_DONE: on i_rd_done go to WAIT_SPACE, or to FLUSH if a VS is pending.
  - FRAME_END: o_busy=0; wait for edge.
- VS edge while in REQ, WAIT_DONE or WAIT_SPACE:
  - Set o_late_vs and set vs_pending.
  - REQ must still complete its ack; never deassert o_rd_req before ack.
  - Outstanding bursts complete, then FLUSH and restart with the i_frame_base sampled at that edge.
  - In WAIT_SPACE the restart is immediate.
- VS edge in FLUSH: restart the flush count and re-latch the base. No late flag.
- Underflow:
  - o_underflow set the cycle after i_de & i_fifo_empty.
  - Not set during FLUSH or IDLE.
- i_err_clr: clears both sticky flags; a set event in the same cycle wins.
- Arithmetic: rd_ptr wraps modulo 2^ADDR_W. i_rd_done without an outstanding burst is ignored.

Test Plan:
- Bench parameters: H_ACTIVE=16, V_ACTIVE=4, BURST_LEN=8, FIFO_DEPTH=32, BYTES_PER_PIXEL=4, base 0x1000, FIFO level model with pops on i_de.
- Nominal frame: VS pulse, ack/done at 3-cycle latency.
  - o_fifo_flush high for 4 cycles.
  - Exactly 8 bursts, len=8, at addresses 0x1000, 0x1020 … 0x10E0.
  - Then FRAME_END with o_busy=0.
- Odd tail: H_ACTIVE=10, V_ACTIVE=1.
  - Two bursts, len 8 then len 2, at 0x1000 and 0x1020.
- Throttle: hold i_fifo_level=25.
  - No o_rd_req issued.
  - Drop level to 24: o_rd_req asserts 2 cycles later.
- Ack stall: hold i_rd_ack=0 for 50 cycles.
  - o_rd_req, addr and len remain stable throughout.
  - Ack: o_rd_req drops next cycle.
- Late VS: edge arrives during WAIT_DONE of burst 3 with new base 0x8000.
  - o_late_vs=1.
  - Flush only after i_rd_done.
  - Next request address is 0x8000.
- Underflow and clear: i_de=1 with i_fifo_empty=1.
  - o_underflow=1 next cycle.
  - i_err_clr pulse clears it.
  - Async reset mid-REQ: all outputs 0 immediately.
